// File: rtl/duck_round_ctrl.sv
// duck_round_ctrl: round sequencer for a single bird FSM.
// Releases birds one at a time, tracks ammo and flight time for each bird,
// reports shot/escape outcomes to the bird FSM, counts hits per round and
// decides whether the player advances to the next round or the game ends.
module duck_round_ctrl #(
  parameter int unsigned AMMO       = 3,    // shots allowed per bird (1..7)
  parameter int unsigned BIRDS      = 10,   // birds per round (1..15)
  parameter int unsigned TIME_LIMIT = 300,  // ticks before forced escape (1..1023)
  parameter int unsigned PASS_HITS  = 6     // hits needed to advance (<= BIRDS)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic       trigger,
  input  logic       hit,
  input  logic [3:0] bird_state,
  output logic       bird_enable,
  output logic       shot,
  output logic       out_of_ammo,
  output logic [2:0] ammo_left,
  output logic [3:0] bird_idx,
  output logic [3:0] hits,
  output logic [6:0] round_num,
  output logic       round_done,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ACTIVE,
    S_RESOLVE,
    S_ROUND_END,
    S_GAME_OVER
  } state_e;

  localparam logic [2:0] AMMO_INIT  = 3'(AMMO);
  localparam logic [3:0] LAST_BIRD  = 4'(BIRDS - 1);
  localparam logic [3:0] PASS_MIN   = 4'(PASS_HITS);
  // The timer holds the number of ticks already seen, so the tick that
  // arrives while it reads TIME_LIMIT-1 is the one that expires the bird.
  localparam logic [9:0] TIMEOUT_AT = 10'(TIME_LIMIT - 1);
  localparam logic [6:0] ROUND_MAX  = 7'd99;
  localparam logic [3:0] BS_HOLD    = 4'd0;
  localparam logic [3:0] BS_PREHOLD = 4'd9;

  state_e     state_q, state_d;
  logic [2:0] ammo_q, ammo_d;
  logic       shot_q, shot_d;
  logic       ooa_q, ooa_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] hits_q, hits_d;
  logic [6:0] round_q, round_d;
  logic [9:0] timer_q, timer_d;
  logic       new_bird;

  // Next-state and datapath updates for the round sequencer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch instead of a mux.
    state_d  = state_q;
    ammo_d   = ammo_q;
    shot_d   = shot_q;
    ooa_d    = ooa_q;
    idx_d    = idx_q;
    hits_d   = hits_q;
    round_d  = round_q;
    timer_d  = timer_q;
    new_bird = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LAUNCH;
          new_bird = 1'b1;
        end
      end

      S_LAUNCH: begin
        // The bird FSM must be parked in HOLD before it may take off.
        if (bird_state == BS_HOLD) begin
          state_d = S_ACTIVE;
          timer_d = '0;
        end
      end

      S_ACTIVE: begin
        // The timer keeps counting even on a tick that a trigger masks, so
        // a masked expiry is still caught on the following tick.
        if (tick && (timer_q != '1)) begin
          timer_d = timer_q + 10'd1;
        end
        if (trigger) begin
          if (ammo_q != '0) begin
            ammo_d = ammo_q - 3'd1;
          end
          if (hit) begin
            shot_d  = 1'b1;
            state_d = S_RESOLVE;
          end else if (ammo_q <= 3'd1) begin
            ooa_d   = 1'b1;
            state_d = S_RESOLVE;
          end
        end else if (tick && (timer_q >= TIMEOUT_AT)) begin
          ooa_d   = 1'b1;
          state_d = S_RESOLVE;
        end
      end

      S_RESOLVE: begin
        // PREHOLD marks the bird's return after falling or flying away.
        if (bird_state == BS_PREHOLD) begin
          if (shot_q) begin
            hits_d = hits_q + 4'd1;
          end
          if (idx_q == LAST_BIRD) begin
            state_d = S_ROUND_END;
          end else begin
            idx_d    = idx_q + 4'd1;
            state_d  = S_LAUNCH;
            new_bird = 1'b1;
          end
        end
      end

      S_ROUND_END: begin
        if (hits_q >= PASS_MIN) begin
          round_d  = (round_q >= ROUND_MAX) ? ROUND_MAX : round_q + 7'd1;
          hits_d   = '0;
          idx_d    = '0;
          state_d  = S_LAUNCH;
          new_bird = 1'b1;
        end else begin
          state_d = S_GAME_OVER;
        end
      end

      S_GAME_OVER: begin
        // Counters keep their final values on display until a new game.
        if (start) begin
          round_d  = 7'd1;
          hits_d   = '0;
          idx_d    = '0;
          state_d  = S_LAUNCH;
          new_bird = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every entry into LAUNCH hands the next bird a full magazine and
    // withdraws the previous bird's outcome flags.
    if (new_bird) begin
      ammo_d = AMMO_INIT;
      shot_d = 1'b0;
      ooa_d  = 1'b0;
    end
  end

  // State and datapath registers; reset aborts any flight immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ammo_q  <= AMMO_INIT;
      shot_q  <= 1'b0;
      ooa_q   <= 1'b0;
      idx_q   <= '0;
      hits_q  <= '0;
      round_q <= 7'd1;
      timer_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      ammo_q  <= ammo_d;
      shot_q  <= shot_d;
      ooa_q   <= ooa_d;
      idx_q   <= idx_d;
      hits_q  <= hits_d;
      round_q <= round_d;
      timer_q <= timer_d;
    end
  end

  assign bird_enable = (state_q == S_ACTIVE);
  assign round_done  = (state_q == S_ROUND_END);
  assign game_over   = (state_q == S_GAME_OVER);
  assign shot        = shot_q;
  assign out_of_ammo = ooa_q;
  assign ammo_left   = ammo_q;
  assign bird_idx    = idx_q;
  assign hits        = hits_q;
  assign round_num   = round_q;

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Bench for duck_round_ctrl: directed game scenarios, a game-rules model
// compared against every output each cycle, and hand-computed literals.
module tb_duck_round_ctrl;

  localparam int AMMO       = 3;
  localparam int BIRDS      = 10;
  localparam int TIME_LIMIT = 300;
  localparam int PASS_HITS  = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       tick;
  logic       trigger;
  logic       hit;
  logic [3:0] bird_state;
  logic       bird_enable;
  logic       shot;
  logic       out_of_ammo;
  logic [2:0] ammo_left;
  logic [3:0] bird_idx;
  logic [3:0] hits;
  logic [6:0] round_num;
  logic       round_done;
  logic       game_over;

  duck_round_ctrl #(
    .AMMO      (AMMO),
    .BIRDS     (BIRDS),
    .TIME_LIMIT(TIME_LIMIT),
    .PASS_HITS (PASS_HITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tick       (tick),
    .trigger    (trigger),
    .hit        (hit),
    .bird_state (bird_state),
    .bird_enable(bird_enable),
    .shot       (shot),
    .out_of_ammo(out_of_ammo),
    .ammo_left  (ammo_left),
    .bird_idx   (bird_idx),
    .hits       (hits),
    .round_num  (round_num),
    .round_done (round_done),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // ---------------- game-rules model ----------------
  typedef enum int {P_IDLE, P_WAIT_BIRD, P_FLYING, P_WAIT_RETURN, P_TALLY, P_OVER} phase_e;

  phase_e m_phase;
  int     m_ammo, m_idx, m_hits, m_round, m_ticks;
  bit     m_shot, m_ooa;
  bit     m_valid = 1'b0;

  task automatic next_bird();
    m_ammo  = AMMO;
    m_shot  = 1'b0;
    m_ooa   = 1'b0;
    m_phase = P_WAIT_BIRD;
  endtask

  task automatic model_step(input bit r, input bit s, input bit tk, input bit tr,
                            input bit h, input int bs);
    if (r) begin
      m_phase = P_IDLE; m_ammo = AMMO; m_shot = 0; m_ooa = 0;
      m_idx = 0; m_hits = 0; m_round = 1; m_ticks = 0;
      m_valid = 1'b1;
    end else begin
      case (m_phase)
        P_IDLE:      if (s) next_bird();
        P_WAIT_BIRD: if (bs == 0) begin m_phase = P_FLYING; m_ticks = 0; end
        P_FLYING: begin
          if (tk) m_ticks++;
          if (tr) begin
            if (m_ammo > 0) m_ammo--;
            if (h) begin m_shot = 1; m_phase = P_WAIT_RETURN; end
            else if (m_ammo == 0) begin m_ooa = 1; m_phase = P_WAIT_RETURN; end
          end else if (tk && m_ticks >= TIME_LIMIT) begin
            m_ooa = 1; m_phase = P_WAIT_RETURN;
          end
        end
        P_WAIT_RETURN: if (bs == 9) begin
          if (m_shot) m_hits++;
          if (m_idx == BIRDS - 1) m_phase = P_TALLY;
          else begin m_idx++; next_bird(); end
        end
        P_TALLY: begin
          if (m_hits >= PASS_HITS) begin
            m_round = (m_round < 99) ? m_round + 1 : 99;
            m_hits = 0; m_idx = 0; next_bird();
          end else m_phase = P_OVER;
        end
        P_OVER: if (s) begin m_round = 1; m_hits = 0; m_idx = 0; next_bird(); end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  // Capture inputs at the edge, let the DUT settle, then compare everything.
  initial begin
    bit c_r, c_s, c_tk, c_tr, c_h;
    int c_bs;
    forever begin
      @(posedge clk);
      c_r = reset; c_s = start; c_tk = tick; c_tr = trigger; c_h = hit;
      c_bs = int'(bird_state);
      #1;
      model_step(c_r, c_s, c_tk, c_tr, c_h, c_bs);
      if (m_valid) begin
        check("cyc bird_enable", bird_enable, int'(m_phase == P_FLYING));
        check("cyc round_done",  round_done,  int'(m_phase == P_TALLY));
        check("cyc game_over",   game_over,   int'(m_phase == P_OVER));
        check("cyc shot",        shot,        m_shot);
        check("cyc out_of_ammo", out_of_ammo, m_ooa);
        check("cyc ammo_left",   ammo_left,   m_ammo);
        check("cyc bird_idx",    bird_idx,    m_idx);
        check("cyc hits",        hits,        m_hits);
        check("cyc round_num",   round_num,   m_round);
      end
    end
  end

  // ---------------- stimulus helpers (all start and end on a negedge) ----------------
  task automatic pulse(input bit tk, input bit tr, input bit h);
    tick = tk; trigger = tr; hit = h;
    @(negedge clk);
    tick = 1'b0; trigger = 1'b0; hit = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      pulse(1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic wait_enable();
    int n = 0;
    while (!bird_enable && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("lit launch_to_enable", bird_enable, 1);
  endtask

  task automatic return_bird();
    bird_state = 4'd7;
    @(negedge clk);
    bird_state = 4'd9;
    @(negedge clk);
    bird_state = 4'd0;
  endtask

  task automatic hit_bird();
    wait_enable();
    pulse(1'b0, 1'b1, 1'b1);
    return_bird();
  endtask

  task automatic miss_bird();
    wait_enable();
    repeat (AMMO) pulse(1'b0, 1'b1, 1'b0);
    return_bird();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0; trigger = 1'b0; hit = 1'b0;
    bird_state = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("lit rst ammo_left",   ammo_left,   3);
    check("lit rst bird_idx",    bird_idx,    0);
    check("lit rst round_num",   round_num,   1);
    check("lit rst bird_enable", bird_enable, 0);
    check("lit rst game_over",   game_over,   0);

    // Start: LAUNCH one edge, ACTIVE the next.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("lit start enable", bird_enable, 1);
    check("lit start ammo",   ammo_left,   3);

    // Bird 0: three misses, then a fourth trigger that must be ignored.
    pulse(1'b0, 1'b1, 1'b0);
    check("lit miss1 ammo", ammo_left, 2);
    pulse(1'b0, 1'b1, 1'b0);
    check("lit miss2 ammo", ammo_left, 1);
    pulse(1'b0, 1'b1, 1'b0);
    check("lit miss3 ammo", ammo_left, 0);
    check("lit miss3 ooa",  out_of_ammo, 1);
    check("lit miss3 enable", bird_enable, 0);
    pulse(1'b0, 1'b1, 1'b0);
    check("lit miss4 ammo", ammo_left, 0);
    return_bird();
    check("lit b0 idx",  bird_idx, 1);
    check("lit b0 hits", hits, 0);
    check("lit b0 ooa cleared", out_of_ammo, 0);

    // Bird 1: hit on the very tick that would have timed it out.
    wait_enable();
    tick_n(TIME_LIMIT - 1);
    check("lit b1 still flying", bird_enable, 1);
    pulse(1'b1, 1'b1, 1'b1);
    check("lit b1 shot", shot, 1);
    check("lit b1 ooa",  out_of_ammo, 0);
    check("lit b1 ammo", ammo_left, 2);
    return_bird();
    check("lit b1 hits", hits, 1);
    check("lit b1 idx",  bird_idx, 2);

    // Bird 2: no trigger, escape exactly on the TIME_LIMIT-th tick.
    wait_enable();
    tick_n(TIME_LIMIT - 1);
    check("lit b2 ooa before", out_of_ammo, 0);
    pulse(1'b1, 1'b0, 1'b0);
    check("lit b2 ooa at limit", out_of_ammo, 1);
    check("lit b2 enable", bird_enable, 0);
    check("lit b2 hits",   hits, 1);
    return_bird();

    // Birds 3..7 hit, 8..9 missed: 6 hits, round passes.
    for (int i = 3; i < 8; i++) hit_bird();
    for (int i = 8; i < BIRDS; i++) miss_bird();
    check("lit r1 round_done", round_done, 1);
    check("lit r1 hits",       hits, 6);
    @(negedge clk);
    check("lit r1 done pulse", round_done, 0);
    check("lit r2 round_num",  round_num, 2);
    check("lit r2 hits",       hits, 0);
    check("lit r2 idx",        bird_idx, 0);

    // Round 2: only 5 hits, game over.
    for (int i = 0; i < 5; i++) hit_bird();
    for (int i = 5; i < BIRDS; i++) miss_bird();
    check("lit r2 round_done", round_done, 1);
    @(negedge clk);
    check("lit over game_over", game_over, 1);
    check("lit over round_num", round_num, 2);
    check("lit over hits",      hits, 5);
    @(negedge clk);
    check("lit over held", game_over, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lit restart game_over", game_over, 0);
    check("lit restart round_num", round_num, 1);
    check("lit restart hits",      hits, 0);
    check("lit restart idx",       bird_idx, 0);

    // Reset mid-flight with one shot left.
    wait_enable();
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("lit pre-reset ammo", ammo_left, 1);
    #3 reset = 1'b1;
    #1;
    check("lit async enable", bird_enable, 0);
    check("lit async ammo",   ammo_left, 3);
    check("lit async ooa",    out_of_ammo, 0);
    check("lit async round",  round_num, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("lit idle after reset", bird_enable, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/duck_round_ctrl.md
Name: duck_round_ctrl

Overview:
- Game-level sequencer for one bird FSM instance: releases birds one at a time, tracks ammo and flight timeout per bird, and flags shot/escape outcomes into the bird FSM.
- Counts hits per round and decides round pass/fail.
- Sits between the top-level game logic (start button, trigger, frame tick, hit detector) and the bird FSM / score display.

Parameters:
- AMMO, 3, shots allowed per bird (1..7).
- BIRDS, 10, birds per round (1..15).
- TIME_LIMIT, 300, frame ticks a bird may fly before forced escape (1..1023).
- PASS_HITS, 6, hits needed in a round to advance (<= BIRDS).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; begins a game from IDLE or GAME_OVER.
- tick  in  1  one-cycle frame pulse (~60 Hz).
- trigger  in  1  one-cycle pulse per gun trigger pull.
- hit  in  1  qualified with trigger the same cycle: the shot landed on the bird.
- bird_state  in  4  bird FSM state code: 0 HOLD, 7 SHOT, 8 ESCAPE, 9 PREHOLD.
- bird_enable  out  1  high while a bird is in flight (ACTIVE).
- shot  out  1  level to bird FSM: bird was hit.
- out_of_ammo  out  1  level to bird FSM: ammo exhausted or time expired.
- ammo_left  out  3  remaining shots for the current bird.
- bird_idx  out  4  current bird number, 0..BIRDS-1.
- hits  out  4  hits so far this round.
- round_num  out  7  current round, starting at 1, saturating at 99.
- round_done  out  1  one-cycle pulse at the end of each round.
- game_over  out  1  high in the GAME_OVER state.

Behaviour:
- Reset values: state IDLE; bird_enable=0, shot=0, out_of_ammo=0, ammo_left=AMMO, bird_idx=0, hits=0, round_num=1, round_done=0, game_over=0. A reset mid-flight aborts everything immediately.
- Timer: 10-bit count, cleared on entry to ACTIVE, incremented on tick only while in ACTIVE.
- States:
  - IDLE: if start, go to LAUNCH.
  - LAUNCH: clear shot and out_of_ammo, set ammo_left=AMMO. Wait until bird_state==0 (HOLD), then go to ACTIVE. bird_enable is asserted on the ACTIVE transition.
  - ACTIVE:
    - trigger&&hit: ammo_left-1, shot=1, go to RESOLVE.
    - trigger&&!hit: ammo_left-1. If the result is 0, out_of_ammo=1 and go to RESOLVE.
    - Otherwise, if timer reaches TIME_LIMIT: out_of_ammo=1, go to RESOLVE.
    - Priority: hit > miss > timeout when events share a cycle.
    - trigger when ammo_left==0 is impossible here. ammo_left never wraps below 0.
  - RESOLVE: bird_enable=0. Wait for bird_state==9 (PREHOLD), the bird's return after SHOT/ESCAPE. On that cycle, hits+1 if shot. Then:
    - bird_idx==BIRDS-1: go to ROUND_END.
    - Otherwise: bird_idx+1, go to LAUNCH.
  - ROUND_END: one cycle; round_done=1.
    - hits>=PASS_HITS: round_num+1 (saturates at 99), clear hits and bird_idx, go to LAUNCH.
    - Otherwise: go to GAME_OVER.
  - GAME_OVER: game_over=1; all other outputs hold their final values for display.
    - On start: round_num=1, hits=0, bird_idx=0, go to LAUNCH.
- shot and out_of_ammo are mutually exclusive and hold from assertion until the next LAUNCH.
- trigger outside ACTIVE is ignored: no ammo change.
- tick and trigger in the same cycle: the trigger is evaluated first, and the timeout only applies if no trigger occurred.
- The hits counter does not overflow: max value is BIRDS <= 15.

Test Plan:
- Reset, then start=1, with a model bird FSM answering HOLD → bird_enable=1 within 2 cycles; ammo_left=3, bird_idx=0.
- ACTIVE, three trigger pulses with hit=0 → ammo_left 2,1,0; out_of_ammo=1 after the 3rd; bird_enable=0; no further ammo change on a 4th trigger.
- ACTIVE, trigger&&hit with the timer at TIME_LIMIT on the same tick → shot=1, out_of_ammo=0; after bird_state=9, hits=1, bird_idx=1.
- No trigger for 300 ticks → out_of_ammo=1 exactly on the 300th tick; hits unchanged.
- Full round with 6 hits of 10 → round_done pulse, round_num=2, hits=0; repeat with 5 hits → game_over=1, then start gives round_num=1.
- Assert reset while ACTIVE with ammo_left=1 → all outputs at reset values asynchronously; state IDLE.
